// File: rtl/conv_window_receiver.sv
// Purpose: buffers two image rows and emits every 3x3 pixel neighbourhood as one parallel window.
// Latency: one clock from accepting the bottom-right pixel to win_valid (registered outputs).
// Backpressure: none; the upstream may leave gaps in pix_valid, but every accepted pixel is consumed.
module conv_window_receiver #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int PIX_W = 24,
    parameter int CNT_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 frame_start,
    input  logic                 pix_valid,
    input  logic [PIX_W-1:0]     pix_data,
    output logic                 win_valid,
    output logic [9*PIX_W-1:0]   win_data,
    output logic [CNT_W-1:0]     win_row,
    output logic [CNT_W-1:0]     win_col,
    output logic                 frame_done,
    output logic                 busy
);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     row_q, row_d, col_q, col_d;
    logic                 win_valid_q, win_valid_d;
    logic [9*PIX_W-1:0]   win_data_q, win_data_d;
    logic [CNT_W-1:0]     win_row_q, win_row_d, win_col_q, win_col_d;
    logic                 frame_done_q, frame_done_d;
    logic                 busy_q, busy_d;

    // Sliding 3x3 window and the two row buffers carry pixel data only, so they are never reset.
    logic [9*PIX_W-1:0]   sh_q, sh_d;
    logic [PIX_W-1:0]     lb0_mem [IMG_W];
    logic [PIX_W-1:0]     lb1_mem [IMG_W];
    logic [PIX_W-1:0]     new_col [3];

    logic accept, last_col, last_row;

    // The pixel presented alongside an arming/restarting frame_start is dropped.
    assign accept   = pix_valid && (state_q != S_IDLE) && !frame_start;
    assign last_col = (col_q == CNT_W'(IMG_W-1));
    assign last_row = (row_q == CNT_W'(IMG_H-1));

    always_comb begin
        new_col[0] = lb1_mem[col_q];
        new_col[1] = lb0_mem[col_q];
        new_col[2] = pix_data;
        sh_d = sh_q;
        for (int r = 0; r < 3; r++) begin
            sh_d[(3*r+0)*PIX_W +: PIX_W] = sh_q[(3*r+1)*PIX_W +: PIX_W];
            sh_d[(3*r+1)*PIX_W +: PIX_W] = sh_q[(3*r+2)*PIX_W +: PIX_W];
            sh_d[(3*r+2)*PIX_W +: PIX_W] = new_col[r];
        end
    end

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        win_valid_d  = 1'b0;
        win_row_d    = win_row_q;
        win_col_d    = win_col_q;
        frame_done_d = 1'b0;
        if (frame_start) begin
            state_d = S_FILL;
            row_d   = '0;
            col_d   = '0;
        end else if (accept) begin
            if (last_col) begin
                col_d = '0;
                row_d = row_q + CNT_W'(1);
            end else begin
                col_d = col_q + CNT_W'(1);
            end
            if (row_q >= CNT_W'(2) && col_q >= CNT_W'(2)) begin
                win_valid_d = 1'b1;
                win_row_d   = row_q - CNT_W'(2);
                win_col_d   = col_q - CNT_W'(2);
            end
            if (state_q == S_FILL && row_q == CNT_W'(1) && last_col) begin
                state_d = S_RUN;
            end
            if (state_q == S_RUN && last_row && last_col) begin
                state_d      = S_IDLE;
                row_d        = '0;
                col_d        = '0;
                frame_done_d = 1'b1;
            end
        end
        win_data_d = win_valid_d ? sh_d : win_data_q;
        busy_d     = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            row_q        <= '0;
            col_q        <= '0;
            win_valid_q  <= 1'b0;
            win_data_q   <= '0;
            win_row_q    <= '0;
            win_col_q    <= '0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            win_valid_q  <= win_valid_d;
            win_data_q   <= win_data_d;
            win_row_q    <= win_row_d;
            win_col_q    <= win_col_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            sh_q           <= sh_d;
            lb1_mem[col_q] <= lb0_mem[col_q];
            lb0_mem[col_q] <= pix_data;
        end
    end

    assign win_valid  = win_valid_q;
    assign win_data   = win_data_q;
    assign win_row    = win_row_q;
    assign win_col    = win_col_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;

endmodule
